// File: rtl/fft_rd_pkg.sv
// Shared constants, types and helpers for the FFT result reader.
package fft_rd_pkg;

    localparam int LOGN = 32'sd6;
    localparam int N    = 32'sd1 <<< LOGN;
    localparam int W    = 32'sd16;

    typedef logic signed [W-1:0] sample_t;
    typedef logic [LOGN-1:0]     bin_t;
    typedef logic [LOGN-2:0]     pair_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    localparam bin_t    BIN_ZERO   = {LOGN{1'b0}};
    localparam bin_t    BIN_ONE    = {{(LOGN-1){1'b0}}, 1'b1};
    localparam bin_t    BIN_LAST   = {LOGN{1'b1}};
    localparam pair_t   PAIR_ZERO  = {(LOGN-1){1'b0}};
    localparam pair_t   PAIR_ONE   = {{(LOGN-2){1'b0}}, 1'b1};
    localparam pair_t   PAIR_LAST  = {(LOGN-1){1'b1}};
    localparam sample_t SAMPLE_MIN = {1'b1, {(W-1){1'b0}}};
    localparam sample_t SAMPLE_MAX = {1'b0, {(W-1){1'b1}}};
    localparam sample_t SAMPLE_0   = {W{1'b0}};

    // Maps a natural-order bin to the buffer slot the core wrote it to.
    function automatic bin_t bitrev(input bin_t a);
        bin_t r;
        r = BIN_ZERO;
        for (int i = 0; i < LOGN; i++) begin
            r[i] = a[LOGN-1-i];
        end
        return r;
    endfunction

    // Absolute value; the most negative code has no positive twin, so it saturates.
    function automatic sample_t abs_sat(input sample_t s);
        sample_t r;
        if (s == SAMPLE_MIN) begin
            r = SAMPLE_MAX;
        end else if (s[W-1]) begin
            r = -s;
        end else begin
            r = s;
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_result_reader_buf.sv
// 64-entry frame buffer: one two-lane write port (slots 2c, 2c+1), one async read port.
module fft_rd_buf
    import fft_rd_pkg::*;
(
    input  logic    CK,
    input  logic    we,
    input  pair_t   wpair,
    input  sample_t wd1,
    input  sample_t wd2,
    input  bin_t    raddr,
    output sample_t rdata
);

    sample_t mem_r [N];

    // Pair write; contents deliberately survive reset.
    always_ff @(posedge CK) begin
        if (we) begin
            mem_r[{wpair, 1'b0}] <= wd1;
            mem_r[{wpair, 1'b1}] <= wd2;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/fft_result_reader.sv
// Captures a bit-reversed FFT frame and streams it out in natural bin order.
// Build option: FFT_RD_MAGNITUDE_EN outputs saturated |sample| instead of the raw value.
module fft_result_reader
    import fft_rd_pkg::*;
(
    input  logic            CK,
    input  logic            RST,
    input  logic            FI,
    input  logic [W-1:0]    D1,
    input  logic [W-1:0]    D2,
    output logic [W-1:0]    DOUT,
    output logic [LOGN-1:0] IDX,
    output logic            DVALID,
    input  logic            DREADY,
    output logic            BUSY,
    output logic            DONE,
    output logic            ERR,
    output logic            OVF
);

    state_t  state_r, next_state_s;
    pair_t   cnt_r, wr_pair_s;
    bin_t    n_r, idx_r;
    sample_t dout_r, rd_data_s, out_sample_s;
    logic    fi_q_r, fi_arm_r, fi_rise_s;
    logic    dvalid_r, busy_r, done_r, err_r, ovf_r;
    logic    wr_en_s, present_s, finish_s, err_s, ovf_s;

    // FI held high out of reset must not count as an edge until it has been seen low.
    assign fi_rise_s = FI & ~fi_q_r & fi_arm_r;

    fft_rd_buf u_buf (
        .CK    (CK),
        .we    (wr_en_s),
        .wpair (wr_pair_s),
        .wd1   (sample_t'(D1)),
        .wd2   (sample_t'(D2)),
        .raddr (bitrev(n_r)),
        .rdata (rd_data_s)
    );

`ifdef FFT_RD_MAGNITUDE_EN
    assign out_sample_s = abs_sat(rd_data_s);
`else
    assign out_sample_s = rd_data_s;
`endif

    // Next-state and per-cycle control decode.
    always_comb begin
        next_state_s = state_r;
        wr_en_s      = 1'b0;
        wr_pair_s    = cnt_r;
        present_s    = 1'b0;
        finish_s     = 1'b0;
        err_s        = 1'b0;
        ovf_s        = 1'b0;
        case (state_r)
            IDLE: begin
                if (fi_rise_s) begin
                    wr_en_s      = 1'b1;
                    wr_pair_s    = PAIR_ZERO;
                    next_state_s = CAPTURE;
                end else begin
                    next_state_s = IDLE;
                end
            end
            CAPTURE: begin
                if (FI) begin
                    wr_en_s = 1'b1;
                    if (cnt_r == PAIR_LAST) begin
                        next_state_s = DRAIN;
                    end else begin
                        next_state_s = CAPTURE;
                    end
                end else begin
                    err_s        = 1'b1;
                    next_state_s = IDLE;
                end
            end
            DRAIN: begin
                ovf_s = fi_rise_s;
                if (dvalid_r && DREADY && (idx_r == BIN_LAST)) begin
                    finish_s     = 1'b1;
                    next_state_s = IDLE;
                end else if (!dvalid_r || DREADY) begin
                    present_s = 1'b1;
                end else begin
                    present_s = 1'b0;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge CK) begin
        if (!RST) begin
            state_r  <= IDLE;
            cnt_r    <= PAIR_ZERO;
            n_r      <= BIN_ZERO;
            idx_r    <= BIN_ZERO;
            dout_r   <= SAMPLE_0;
            fi_q_r   <= 1'b0;
            fi_arm_r <= 1'b0;
            dvalid_r <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
            ovf_r    <= 1'b0;
        end else begin
            state_r  <= next_state_s;
            fi_q_r   <= FI;
            fi_arm_r <= fi_arm_r | ~FI;
            busy_r   <= (next_state_s != IDLE);
            done_r   <= finish_s;
            err_r    <= err_s;
            ovf_r    <= ovf_s;
            if (wr_en_s) begin
                cnt_r <= wr_pair_s + PAIR_ONE;
            end
            if (state_r != DRAIN) begin
                n_r <= BIN_ZERO;
            end else if (present_s) begin
                n_r <= n_r + BIN_ONE;
            end
            if (present_s) begin
                dout_r   <= out_sample_s;
                idx_r    <= n_r;
                dvalid_r <= 1'b1;
            end else if (finish_s) begin
                dvalid_r <= 1'b0;
            end
        end
    end

    assign DOUT   = dout_r;
    assign IDX    = idx_r;
    assign DVALID = dvalid_r;
    assign BUSY   = busy_r;
    assign DONE   = done_r;
    assign ERR    = err_r;
    assign OVF    = ovf_r;

endmodule

// File: tb/tb_fft_result_reader.sv
// Directed, table-driven bench for fft_result_reader.
module tb_fft_result_reader;
    import fft_rd_pkg::*;

    logic        CK = 1'b0;
    logic        RST = 1'b0;
    logic        FI = 1'b0;
    logic        DREADY = 1'b1;
    logic [15:0] D1 = 16'h0000;
    logic [15:0] D2 = 16'h0000;
    logic [15:0] DOUT;
    logic [5:0]  IDX;
    logic        DVALID, BUSY, DONE, ERR, OVF;

    always #5 CK = ~CK;

    fft_result_reader dut (
        .CK(CK), .RST(RST), .FI(FI), .D1(D1), .D2(D2),
        .DOUT(DOUT), .IDX(IDX), .DVALID(DVALID), .DREADY(DREADY),
        .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .OVF(OVF)
    );

    typedef struct {
        int          idx;
        logic [15:0] dout;
    } vec_t;

    vec_t        ramp_tab [8];
    logic [15:0] got_dout [64];
    int          got_idx  [64];
    int checks = 0;
    int errors = 0;
    int nacc, ndone, novf, nheld, first_valid, done_busy;
    int nerr, ndv, nbusy, w;
    logic hit;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic int brev6(input int v);
        int r = 0;
        for (int b = 0; b < 6; b++) if (v & (1 << b)) r |= (1 << (5 - b));
        return r;
    endfunction

    function automatic logic [15:0] pval(input int mode, input int i);
        if (mode == 0) return 16'(i);
        if (mode == 1) return 16'(16'h1000 + i);
        if (i == 0)  return 16'hFF00;
        if (i == 32) return 16'h8000;
        if (i == 16) return 16'h0123;
        return 16'h0000;
    endfunction

    task automatic send_frame(input int mode, input int npairs);
        for (int c = 0; c < npairs; c++) begin
            @(negedge CK);
            FI = 1'b1; D1 = pval(mode, 2 * c); D2 = pval(mode, 2 * c + 1);
        end
        @(negedge CK);
        FI = 1'b0; D1 = 16'h0000; D2 = 16'h0000;
    endtask

    task automatic drain(input int stall_idx, input int stall_len, input int ovf_idx);
        int stalls = 0;
        int cyc = 0;
        int after = 0;
        nacc = 0; ndone = 0; novf = 0; nheld = 0; first_valid = -1; done_busy = -1;
        DREADY = 1'b1;
        while (cyc < 400 && after < 4) begin
            @(negedge CK);
            cyc++;
            if (DONE) begin ndone++; done_busy = int'(BUSY); end
            if (OVF) novf++;
            if (ndone > 0) after++;
            if (DVALID) begin
                if (first_valid < 0) first_valid = cyc;
                if (int'(IDX) == stall_idx) nheld++;
                if (int'(IDX) == ovf_idx) begin FI = 1'b1; D1 = 16'h5555; D2 = 16'h5555; end
                if (int'(IDX) == stall_idx && stalls < stall_len) begin
                    DREADY = 1'b0; stalls++;
                end else begin
                    DREADY = 1'b1;
                    if (nacc < 64) begin got_dout[nacc] = DOUT; got_idx[nacc] = int'(IDX); end
                    nacc++;
                end
            end else begin
                DREADY = 1'b1;
            end
        end
        FI = 1'b0; D1 = 16'h0000; D2 = 16'h0000; DREADY = 1'b1;
    endtask

    task automatic verify_ramp(input string tag);
        chk({tag, "_count"}, nacc, 64);
        chk({tag, "_done_pulses"}, ndone, 1);
        chk({tag, "_busy_at_done"}, done_busy, 0);
        for (int t = 0; t < 8; t++) begin
            chk($sformatf("%s_tab_idx%0d", tag, ramp_tab[t].idx), got_idx[ramp_tab[t].idx], ramp_tab[t].idx);
            chk($sformatf("%s_tab_dout%0d", tag, ramp_tab[t].idx), int'(got_dout[ramp_tab[t].idx]), int'(ramp_tab[t].dout));
        end
        for (int i = 0; i < 64; i++) begin
            chk($sformatf("%s_bin%0d", tag, i), int'(got_dout[i]), brev6(i));
        end
    endtask

    initial begin
        ramp_tab[0] = '{0, 16'd0};   ramp_tab[1] = '{1, 16'd32};
        ramp_tab[2] = '{2, 16'd16};  ramp_tab[3] = '{3, 16'd48};
        ramp_tab[4] = '{4, 16'd8};   ramp_tab[5] = '{5, 16'd40};
        ramp_tab[6] = '{6, 16'd24};  ramp_tab[7] = '{63, 16'd63};

        // Reset, with FI already high: all outputs cleared
        FI = 1'b1;
        repeat (3) @(negedge CK);
        chk("rst_dvalid", int'(DVALID), 0);
        chk("rst_busy", int'(BUSY), 0);
        chk("rst_done", int'(DONE), 0);
        chk("rst_err", int'(ERR), 0);
        chk("rst_ovf", int'(OVF), 0);
        chk("rst_dout", int'(DOUT), 0);
        chk("rst_idx", int'(IDX), 0);
        RST = 1'b1;
        nbusy = 0;
        repeat (5) begin @(negedge CK); if (BUSY) nbusy++; end
        chk("fi_high_from_reset_ignored", nbusy, 0);
        FI = 1'b0;
        @(negedge CK);

        // Ramp frame, full throughput
        send_frame(0, 32);
        chk("lat_busy_after_last_pair", int'(BUSY), 1);
        chk("lat_dvalid_after_last_pair", int'(DVALID), 0);
        drain(-1, 0, -1);
        chk("lat_first_valid_cycle", first_valid, 2 - 1);
        verify_ramp("ramp");

        // Backpressure at bin 5
        send_frame(0, 32);
        drain(5, 3, -1);
        chk("bp_held_cycles", nheld, 4);
        chk("bp_after_idx", got_idx[6], 6);
        chk("bp_after_dout", int'(got_dout[6]), 24);
        verify_ramp("bp");

        // Truncated frame
        send_frame(1, 10);
        nerr = 0; ndv = 0;
        repeat (8) begin @(negedge CK); if (ERR) nerr++; if (DVALID) ndv++; end
        chk("trunc_err_pulses", nerr, 1);
        chk("trunc_no_dvalid", ndv, 0);
        chk("trunc_idle", int'(BUSY), 0);
        send_frame(0, 32);
        drain(-1, 0, -1);
        verify_ramp("post_trunc");

        // Overflow: new FI edge during drain at n=20
        send_frame(0, 32);
        drain(-1, 0, 20);
        chk("ovf_pulses", novf, 1);
        verify_ramp("ovf");
        ndv = 0; nbusy = 0;
        repeat (10) begin @(negedge CK); if (DVALID) ndv++; if (BUSY) nbusy++; end
        chk("ovf_no_second_drain", ndv, 0);
        chk("ovf_stays_idle", nbusy, 0);

        // Reset mid-drain at n=30
        send_frame(0, 32);
        w = 0; hit = 1'b0;
        while (w < 100 && !hit) begin
            @(negedge CK); w++;
            if (DVALID && IDX == 6'd30) hit = 1'b1;
        end
        chk("rst_mid_reached_n30", int'(hit), 1);
        RST = 1'b0;
        @(negedge CK);
        chk("rst_mid_dvalid", int'(DVALID), 0);
        chk("rst_mid_busy", int'(BUSY), 0);
        chk("rst_mid_done", int'(DONE), 0);
        RST = 1'b1;
        ndone = 0;
        repeat (4) begin @(negedge CK); if (DONE) ndone++; end
        chk("rst_mid_no_done_after", ndone, 0);
        send_frame(0, 32);
        drain(-1, 0, -1);
        chk("rst_mid_restart_idx0", got_idx[0], 0);
        verify_ramp("post_rst");

        // Sign handling (raw vs magnitude build)
        send_frame(2, 32);
        drain(-1, 0, -1);
        chk("mag_count", nacc, 64);
`ifdef FFT_RD_MAGNITUDE_EN
        chk("mag_idx0", int'(got_dout[0]), 32'h0100);
        chk("mag_idx1", int'(got_dout[1]), 32'h7FFF);
`else
        chk("mag_idx0", int'(got_dout[0]), 32'hFF00);
        chk("mag_idx1", int'(got_dout[1]), 32'h8000);
`endif
        chk("mag_idx2", int'(got_dout[2]), 32'h0123);
        chk("mag_idx3", int'(got_dout[3]), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fft_result_reader.md
Name: fft_result_reader

Overview:
- Consumer at the output side of the 64-point FFT core.
- Captures the 32 result pairs the core presents while its finish flag FI is high. The core delivers them in bit-reversed order.
- Stores them in a 64-entry buffer, then drains them as a valid/ready stream in natural frequency order (bin 0..63) with the bin index attached.
- Sits between the FFT core and downstream spectrum logic (display/peak detect).

Parameters:
- LOGN, 6, log2 of FFT points; N = 2**LOGN = 64, pairs per frame = N/2 = 32.
- W, 16, sample width (signed two's complement, real part only).

Ports:
- CK  input  1  clock, rising edge.
- RST  input  1  reset, synchronous, active-low.
- FI  input  1  FFT finish flag; high for one frame of N/2 cycles.
- D1  input  W  FFT result, even lane (capture index 2c).
- D2  input  W  FFT result, odd lane (capture index 2c+1).
- DOUT  output  W  result sample, natural order.
- IDX  output  LOGN  bin index of DOUT.
- DVALID  output  1  DOUT/IDX valid.
- DREADY  input  1  downstream accepts when DVALID&DREADY.
- BUSY  output  1  high in CAPTURE or DRAIN.
- DONE  output  1  one-cycle pulse after bin N-1 is accepted.
- ERR  output  1  one-cycle pulse: frame truncated (FI fell before N/2 pairs).
- OVF  output  1  one-cycle pulse: FI rising edge while DRAIN; that frame is dropped.

Behaviour:
- Reset (RST=0 at posedge):
  - state=IDLE; DOUT=0, IDX=0, DVALID=0, BUSY=0, DONE=0, ERR=0, OVF=0.
  - Capture count and drain count cleared; FI edge register cleared.
  - Buffer contents are not cleared.
  - Reset mid-CAPTURE or mid-DRAIN aborts the frame, with no DONE/ERR.
- FI edge detect uses a registered copy fi_q. A rising edge is FI & ~fi_q.
- IDLE:
  - FI rising edge writes D1->buf[0], D2->buf[1] in that same cycle.
  - cnt=1; go to CAPTURE.
  - FI already high out of reset is not an edge; it is ignored until FI goes low and high again.
- CAPTURE:
  - Each cycle with FI=1: buf[2*cnt]<=D1, buf[2*cnt+1]<=D2, cnt++.
  - After the write with cnt==N/2-1: go to DRAIN with n=0.
  - FI=0 before that point: ERR pulse next cycle, go to IDLE, no output.
  - FI staying high after N/2 pairs is ignored.
- DRAIN:
  - Read address = bitrev_LOGN(n); DOUT/IDX/DVALID are registered.
  - DVALID rises 1 cycle after entering DRAIN with IDX=0.
  - DOUT/IDX are held stable while DVALID&~DREADY.
  - On acceptance, the next bin is presented the following cycle, so throughput is 1 sample/cycle under DREADY=1.
  - Acceptance of n=N-1: DVALID=0, DONE=1 for one cycle, go to IDLE.
  - A new frame may start in the cycle after DONE.
  - FI rising edge in DRAIN: OVF pulse, frame ignored; DRAIN continues.
- BUSY = (state != IDLE).
- Total latency, last captured pair to IDX=0 valid: 2 cycles.
- Data is copied unmodified (no scaling) unless the optional feature is enabled.

Optional Feature:
- Macro FFT_RD_MAGNITUDE_EN.
- Defined: DOUT = |sample|. 0x8000 saturates to 0x7FFF. The abs stage is combinational before the DOUT register, so there is no latency change.
- Undefined: DOUT = signed sample as captured.

Decomposition:
- Package fft_rd_pkg:
  - LOGN/N/W constants.
  - State enum {IDLE, CAPTURE, DRAIN}.
  - bitrev function (LOGN-bit reversal).
  - Sample typedef.
- One natural sub-module: fft_rd_buf, the 64xW dual-port register file with one write port taking two lanes (addresses 2c and 2c+1) and one read port.
- FSM, counters and output register stay in the top.

Test Plan:
- Ramp frame: FI high 32 cycles with D1=2c, D2=2c+1, DREADY=1 -> 64 outputs in consecutive cycles, e.g. IDX=0 DOUT=0, IDX=1 DOUT=32, IDX=2 DOUT=16, IDX=5 DOUT=40, IDX=63 DOUT=63. Then DONE pulses once and BUSY falls.
- Backpressure: same frame, DREADY=0 for 3 cycles while IDX=5 -> DOUT=40, IDX=5 held for 4 cycles, then IDX=6 DOUT=24. Total sample count stays 64.
- Truncated frame: FI high 10 cycles -> ERR pulse, DVALID never asserts, state IDLE. A following full frame drains correctly.
- Overflow: FI rising edge at drain n=20 -> OVF pulse, the drain of the original frame completes unchanged (IDX=63 DOUT=63), and no second drain follows.
- Reset mid-drain: RST=0 at n=30 -> next cycle DVALID=0, BUSY=0, no DONE. A subsequent frame starts from IDX=0.
- FFT_RD_MAGNITUDE_EN: capture values 0xFF00, 0x8000, 0x0123 at capture indices 0, 32, 16 -> outputs IDX0=0x0100, IDX1=0x7FFF, IDX2=0x0123.
